// File: rtl/bus_responder.sv
// Byte-wide RAM slave with a fixed wait-state count. Accesses outside the
// address window complete normally but return MISS_DATA and flag miss.
module bus_responder #(
   parameter logic [15:0] BASE_ADDR   = 16'h0200,
   parameter int          DEPTH_LOG2  = 5,
   parameter int          WAIT_STATES = 1,
   parameter logic [7:0]  MISS_DATA   = 8'hEA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [15:0] address,
   input  logic        rw,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdy,
   output logic        ack,
   output logic        miss,
   output logic        busy
);

   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
   localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   function automatic logic addr_hit(input logic [15:0] a);
      return a[15:DEPTH_LOG2] == BASE_ADDR[15:DEPTH_LOG2];
   endfunction

   state_t                  state_r, next_state_s;
   logic [3:0]              wait_cnt_r, wait_next_s;
   logic                    accept_s;
   logic [15:0]             addr_r, lat_addr_s;
   logic                    rw_r, lat_rw_s;
   logic [7:0]              wdata_r, rd_val_s;
   logic [DEPTH_LOG2-1:0]   lat_idx_s, cur_idx_s;
   logic                    lat_hit_s;
   logic [7:0]              ram_r [DEPTH];
   logic [7:0]              rdata_r;
   logic                    rdy_r, ack_r, miss_r, busy_r;

   // Next-state and wait-counter logic; req is only sampled in IDLE and RESP.
   always_comb begin
      next_state_s = state_r;
      wait_next_s  = wait_cnt_r;
      accept_s     = 1'b0;
      case (state_r)
         ST_IDLE, ST_RESP: begin
            if (req) begin
               accept_s = 1'b1;
               if (HAS_WAIT) begin
                  next_state_s = ST_WAIT;
                  wait_next_s  = WAIT_LOAD;
               end else begin
                  next_state_s = ST_RESP;
                  wait_next_s  = 4'd0;
               end
            end else begin
               next_state_s = ST_IDLE;
               wait_next_s  = 4'd0;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_r == 4'd0) begin
               next_state_s = ST_RESP;
            end else begin
               wait_next_s = wait_cnt_r - 4'd1;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
            wait_next_s  = 4'd0;
         end
      endcase
   end

   // Request that will be served on entry to RESP, plus its read data.
   // With zero wait states a read can follow a write to the same byte on the
   // very edge that commits the write, so the pending write data is forwarded.
   always_comb begin
      if (accept_s) begin
         lat_addr_s = address;
         lat_rw_s   = rw;
      end else begin
         lat_addr_s = addr_r;
         lat_rw_s   = rw_r;
      end
      lat_idx_s = lat_addr_s[DEPTH_LOG2-1:0];
      cur_idx_s = addr_r[DEPTH_LOG2-1:0];
      lat_hit_s = addr_hit(lat_addr_s);
      if ((state_r == ST_RESP) && !rw_r && addr_hit(addr_r) && (cur_idx_s == lat_idx_s)) begin
         rd_val_s = wdata_r;
      end else begin
         rd_val_s = ram_r[lat_idx_s];
      end
   end

   // State, wait counter and latched request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= 4'd0;
         addr_r     <= 16'h0000;
         rw_r       <= 1'b0;
         wdata_r    <= 8'h00;
      end else begin
         state_r    <= next_state_s;
         wait_cnt_r <= wait_next_s;
         if (accept_s) begin
            addr_r  <= address;
            rw_r    <= rw;
            wdata_r <= wdata;
         end
      end
   end

   // RAM array; a write hit commits on the edge leaving RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram_r[i] <= 8'h00;
         end
      end else if ((state_r == ST_RESP) && !rw_r && addr_hit(addr_r)) begin
         ram_r[cur_idx_s] <= wdata_r;
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= 8'h00;
         rdy_r   <= 1'b1;
         ack_r   <= 1'b0;
         miss_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         rdy_r  <= (next_state_s != ST_WAIT);
         busy_r <= (next_state_s != ST_IDLE);
         ack_r  <= (next_state_s == ST_RESP);
         miss_r <= (next_state_s == ST_RESP) && !lat_hit_s;
         if ((next_state_s == ST_RESP) && lat_rw_s) begin
            rdata_r <= lat_hit_s ? rd_val_s : MISS_DATA;
         end
      end
   end

   assign rdata = rdata_r;
   assign rdy   = rdy_r;
   assign ack   = ack_r;
   assign miss  = miss_r;
   assign busy  = busy_r;

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder with three wait-state configurations
// (1, 0 and 15) sharing address/rw/wdata but with separate strobes.
module tb_bus_responder;

   typedef struct packed {
      logic [7:0] rdata;
      logic       miss;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] address;
   logic        rw;
   logic [7:0]  wdata;
   logic        req_a   [3];
   logic [7:0]  rdata_a [3];
   logic        rdy_a   [3];
   logic        ack_a   [3];
   logic        miss_a  [3];
   logic        busy_a  [3];

   exp_t q0[$], q1[$], q2[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   bus_responder #(.WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst_n(rst_n), .req(req_a[0]), .address(address), .rw(rw), .wdata(wdata),
      .rdata(rdata_a[0]), .rdy(rdy_a[0]), .ack(ack_a[0]), .miss(miss_a[0]), .busy(busy_a[0]));

   bus_responder #(.WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .req(req_a[1]), .address(address), .rw(rw), .wdata(wdata),
      .rdata(rdata_a[1]), .rdy(rdy_a[1]), .ack(ack_a[1]), .miss(miss_a[1]), .busy(busy_a[1]));

   bus_responder #(.WAIT_STATES(15)) u_ws15 (
      .clk(clk), .rst_n(rst_n), .req(req_a[2]), .address(address), .rw(rw), .wdata(wdata),
      .rdata(rdata_a[2]), .rdy(rdy_a[2]), .ack(ack_a[2]), .miss(miss_a[2]), .busy(busy_a[2]));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input int k, input logic [7:0] rd, input logic m);
      exp_t e;
      e.rdata = rd;
      e.miss  = m;
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   // Monitor: every ack pops one expectation for that instance.
   always @(negedge clk) begin
      exp_t e;
      bit   have;
      for (int k = 0; k < 3; k++) begin
         if (ack_a[k] === 1'b1) begin
            have = 1'b0;
            case (k)
               0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ack inst=%0d: got ack=1, expected no ack", k);
            end else begin
               chk($sformatf("ack_rdata[%0d]", k), 32'(rdata_a[k]), 32'(e.rdata));
               chk($sformatf("ack_miss[%0d]", k), 32'(miss_a[k]), 32'(e.miss));
               chk($sformatf("ack_rdy[%0d]", k), 32'(rdy_a[k]), 32'd1);
               chk($sformatf("ack_busy[%0d]", k), 32'(busy_a[k]), 32'd1);
            end
         end
      end
   end

   // Single access with latency and stall-length check (exp_lat = 1 + wait states).
   task automatic access(input int k, input logic [15:0] a, input logic r, input logic [7:0] wd,
                         input logic [7:0] exp_rd, input logic exp_miss, input int exp_lat);
      int cyc;
      int low;
      @(negedge clk);
      address  = a;
      rw       = r;
      wdata    = wd;
      req_a[k] = 1'b1;
      push(k, exp_rd, exp_miss);
      cyc = 0;
      low = 0;
      while (cyc < 40) begin
         @(negedge clk);
         req_a[k] = 1'b0;
         cyc++;
         if (rdy_a[k] !== 1'b1) low++;
         if (ack_a[k] === 1'b1) break;
      end
      chk($sformatf("latency[%0d] %h", k, a), 32'(cyc), 32'(exp_lat));
      chk($sformatf("rdy_low[%0d] %h", k, a), 32'(low), 32'(exp_lat - 1));
   endtask

   task automatic chk_reset(input int k);
      chk($sformatf("rst_rdy[%0d]", k), 32'(rdy_a[k]), 32'd1);
      chk($sformatf("rst_ack[%0d]", k), 32'(ack_a[k]), 32'd0);
      chk($sformatf("rst_miss[%0d]", k), 32'(miss_a[k]), 32'd0);
      chk($sformatf("rst_busy[%0d]", k), 32'(busy_a[k]), 32'd0);
      chk($sformatf("rst_rdata[%0d]", k), 32'(rdata_a[k]), 32'h00);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      address = 16'h0000;
      rw      = 1'b0;
      wdata   = 8'h00;
      for (int k = 0; k < 3; k++) req_a[k] = 1'b0;
      #12;
      for (int k = 0; k < 3; k++) chk_reset(k);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write/read, misses and window wrap on the one-wait-state instance.
      access(0, 16'h0205, 1'b0, 8'h5A, 8'h00, 1'b0, 2);
      access(0, 16'h0205, 1'b1, 8'h00, 8'h5A, 1'b0, 2);
      access(0, 16'h0300, 1'b1, 8'h00, 8'hEA, 1'b1, 2);
      access(0, 16'h0300, 1'b0, 8'h77, 8'hEA, 1'b1, 2);
      access(0, 16'h0200, 1'b1, 8'h00, 8'h00, 1'b0, 2);

      // Back-to-back with req held high; address/rw changes during WAIT are ignored.
      @(negedge clk);
      address = 16'h021F; rw = 1'b0; wdata = 8'hC3; req_a[0] = 1'b1;
      push(0, 8'h00, 1'b0);
      @(negedge clk);
      rw = 1'b1;
      push(0, 8'hC3, 1'b0);
      @(negedge clk);
      @(negedge clk);
      address = 16'h0220;
      push(0, 8'hEA, 1'b1);
      @(negedge clk);
      @(negedge clk);
      req_a[0] = 1'b0;
      @(negedge clk);
      access(0, 16'h0220, 1'b0, 8'h55, 8'hEA, 1'b1, 2);
      access(0, 16'h0200, 1'b1, 8'h00, 8'h00, 1'b0, 2);
      access(0, 16'h021F, 1'b1, 8'h00, 8'hC3, 1'b0, 2);

      // Zero wait states, including write-then-read of the same byte back-to-back.
      access(1, 16'h0211, 1'b0, 8'h6B, 8'h00, 1'b0, 1);
      access(1, 16'h0211, 1'b1, 8'h00, 8'h6B, 1'b0, 1);
      access(1, 16'h0311, 1'b1, 8'h00, 8'hEA, 1'b1, 1);
      @(negedge clk);
      address = 16'h0212; rw = 1'b0; wdata = 8'hAB; req_a[1] = 1'b1;
      push(1, 8'hEA, 1'b0);
      @(negedge clk);
      rw = 1'b1;
      push(1, 8'hAB, 1'b0);
      @(negedge clk);
      req_a[1] = 1'b0;
      access(1, 16'h0212, 1'b1, 8'h00, 8'hAB, 1'b0, 1);

      // Fifteen wait states with inputs and req toggling throughout WAIT.
      @(negedge clk);
      address = 16'h0203; rw = 1'b0; wdata = 8'h44; req_a[2] = 1'b1;
      push(2, 8'h00, 1'b0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         address  = 16'h0200 + 16'(i);
         wdata    = 8'(i);
         rw       = i[0];
         req_a[2] = ~i[0];
      end
      @(negedge clk);
      req_a[2] = 1'b0;
      repeat (2) @(negedge clk);
      access(2, 16'h0203, 1'b1, 8'h00, 8'h44, 1'b0, 16);
      access(2, 16'h020E, 1'b1, 8'h00, 8'h00, 1'b0, 16);

      // Reset during WAIT of a write aborts it.
      @(negedge clk);
      address = 16'h0201; rw = 1'b0; wdata = 8'hFF; req_a[0] = 1'b1;
      @(negedge clk);
      req_a[0] = 1'b0;
      chk("mid_busy", 32'(busy_a[0]), 32'd1);
      chk("mid_rdy", 32'(rdy_a[0]), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset(0);
      @(negedge clk);
      rst_n = 1'b1;
      access(0, 16'h0201, 1'b1, 8'h00, 8'h00, 1'b0, 2);
      access(0, 16'h0205, 1'b1, 8'h00, 8'h00, 1'b0, 2);

      repeat (3) @(negedge clk);
      chk("pending_q0", 32'(q0.size()), 32'd0);
      chk("pending_q1", 32'(q1.size()), 32'd0);
      chk("pending_q2", 32'(q2.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0200, start of the RAM window; low DEPTH_LOG2 bits SHALL be zero.
REQ-002 Parameter DEPTH_LOG2, default 5, log2 of RAM depth in bytes (32).
REQ-003 Parameter WAIT_STATES, default 1, rdy-low cycles per access, range 0..15.
REQ-004 Parameter MISS_DATA, default 8'hEA (NOP opcode), read data for out-of-window addresses.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req  in  1  access strobe; address/rw/wdata valid when high.
REQ-008 address  in  16  byte address from core.
REQ-009 rw  in  1  1 = read, 0 = write.
REQ-010 wdata  in  8  write data.
REQ-011 rdata  out  8  read data, valid when ack=1 on a read.
REQ-012 rdy  out  1  0 = responder stalling core.
REQ-013 ack  out  1  one-cycle access-complete pulse.
REQ-014 miss  out  1  one-cycle pulse with ack when address was outside the window.
REQ-015 busy  out  1  high in WAIT and RESP.

Function
REQ-016 States SHALL be IDLE, WAIT, RESP; encoding free.
REQ-017 IDLE: rdy=1, ack=0, busy=0; req=1 at edge SHALL latch address, rw, wdata and go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
REQ-018 Entering WAIT SHALL load wait counter with WAIT_STATES-1; in WAIT rdy=0 and counter decrements each cycle.
REQ-019 WAIT SHALL go to RESP on the edge where the counter is 0.
REQ-020 Latency: req sampled at edge N SHALL give ack=1 during cycle N+1+WAIT_STATES; rdy=0 for exactly WAIT_STATES cycles before it.
REQ-021 RESP: ack=1, rdy=1, busy=1 for exactly one cycle.
REQ-022 Hit: latched address[15:DEPTH_LOG2] == BASE_ADDR[15:DEPTH_LOG2]; RAM index = address[DEPTH_LOG2-1:0].
REQ-023 Read hit SHALL drive rdata = RAM[index] from the RESP cycle; read miss SHALL drive rdata = MISS_DATA and miss=1.
REQ-024 Write hit SHALL update RAM[index] on the edge leaving RESP; write miss SHALL leave RAM unchanged, miss=1.
REQ-025 rdata SHALL hold its last read value until the next read completes; writes SHALL NOT change rdata.
REQ-026 req=1 in RESP SHALL be accepted as in IDLE (back-to-back); a read of the address just written SHALL return the new data.
REQ-027 req in WAIT SHALL be ignored; latched request SHALL NOT change.
REQ-028 req=0 in RESP SHALL return to IDLE.
REQ-029 Index wrap: address BASE_ADDR+2^DEPTH_LOG2 SHALL be a miss, not alias to index 0.
REQ-030 Address/rw/wdata changes after acceptance SHALL NOT affect the access in flight.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, rdata=0, rdy=1, ack=0, miss=0, busy=0, wait counter 0, all RAM bytes 8'h00.
REQ-032 Reset mid-access SHALL abort it: no RAM update, no ack; first accepted req after rst_n rises SHALL behave as from IDLE.

Verification (WAIT_STATES=1, BASE_ADDR=16'h0200 unless stated)
REQ-033 Write 8'h5A to 16'h0205, then read 16'h0205 -> rdy low 1 cycle each, ack 2 cycles after each req, read rdata=8'h5A, miss=0.
REQ-034 Read 16'h0300 -> rdata=8'hEA, miss=1 with ack; write 16'h0300 -> RAM unchanged, miss=1.
REQ-035 Back-to-back: req held high, write 16'h021F=8'hC3 then read 16'h021F in RESP cycle -> second ack returns 8'hC3; read 16'h0220 -> miss=1.
REQ-036 WAIT_STATES=0 and =15: read hit -> ack at N+1 with rdy never low; ack at N+16 with rdy low exactly 15 cycles.
REQ-037 Assert rst_n=0 during WAIT of a write 8'hFF to 16'h0201 -> outputs reset immediately, no ack, later read of 16'h0201 returns 8'h00.
REQ-038 Toggle address/wdata during WAIT and req pulses in WAIT -> original access completes unchanged, exactly one ack.
